// File: rtl/equ_pkg.sv
// Shared types and defaults for the per-symbol equalizer sweep controller.
//   equ_state_t : controller FSM state encoding (IDLE, PRIME, SWEEP, DONE)
//   N_SC_DEF    : default number of subcarriers swept per symbol
//   N_SYM_DEF   : default number of symbols per slot
//   PRIME_W     : width of the priming down-counter (PRIME_CYC is 1..15)
package equ_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    SWEEP = 2'd2,
    DONE  = 2'd3
  } equ_state_t;

  localparam int N_SC_DEF  = 12;
  localparam int N_SYM_DEF = 7;
  localparam int PRIME_W   = 4;

endpackage

// File: rtl/equ_mod_cnt.sv
// Modulo-MOD up-counter with enable, synchronous clear and terminal-count flag.
//   clk   : clock
//   rst   : asynchronous reset, active-high
//   en    : advance one step (wraps MOD-1 -> 0)
//   clr   : synchronous clear, wins over en
//   count : current count value
//   tc    : high while count = MOD-1
module equ_mod_cnt #(
  parameter int MOD = 12,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign tc = (count == LAST);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/equ_sweep_ctrl.sv
// Per-symbol equalizer sweep controller. On a start strobe it idles PRIME_CYC
// cycles, then sweeps buffer read addresses 0..N_SC-1, pulses completion and
// advances the symbol-in-slot counter.
//   i_clk_equ             : clock
//   i_rst                 : asynchronous reset, active-high
//   i_done_equ_one_symbol : start strobe (accepted in IDLE and DONE only)
//   i_stall               : holds the sweep address while high
//   i_abort               : drop the current symbol, return to IDLE, clear symbol index
//   o_rd_add_out          : buffer read address (0 outside SWEEP)
//   o_rd_valid            : read address is live this cycle
//   o_rst_ser_par         : active-low serial-to-parallel reset, low on the first read
//   o_sym_idx             : symbol index within the slot
//   o_done_equ            : one-cycle pulse at symbol completion
//   o_done_slot           : one-cycle pulse at completion of the slot's last symbol
//   o_busy                : controller not in IDLE
module equ_sweep_ctrl
  import equ_pkg::*;
#(
  parameter int N_SC      = N_SC_DEF,
  parameter int ADDR_W    = 4,
  parameter int N_SYM     = N_SYM_DEF,
  parameter int SYM_W     = 3,
  parameter int PRIME_CYC = 1
) (
  input  logic              i_clk_equ,
  input  logic              i_rst,
  input  logic              i_done_equ_one_symbol,
  input  logic              i_stall,
  input  logic              i_abort,
  output logic [ADDR_W-1:0] o_rd_add_out,
  output logic              o_rd_valid,
  output logic              o_rst_ser_par,
  output logic [SYM_W-1:0]  o_sym_idx,
  output logic              o_done_equ,
  output logic              o_done_slot,
  output logic              o_busy
);

  localparam logic [PRIME_W-1:0] PRIME_LOAD = PRIME_W'(PRIME_CYC - 1);

  equ_state_t         state, state_next;
  logic [PRIME_W-1:0] prime_cnt, prime_next;

  logic [ADDR_W-1:0]  addr;
  logic               addr_tc;
  logic               addr_en;
  logic [SYM_W-1:0]   sym;
  logic               sym_tc;
  logic               sym_en;

  logic               in_sweep;
  logic               in_done;

  assign in_sweep = (state == SWEEP);
  assign in_done  = (state == DONE);

  // The address counter wraps to 0 on its own when the last address is read,
  // which is exactly the clear needed on the SWEEP -> DONE transition.
  assign addr_en = in_sweep && !i_stall && !i_abort;
  assign sym_en  = in_done && !i_abort;

  equ_mod_cnt #(.MOD(N_SC), .W(ADDR_W)) u_addr_cnt (
    .clk   (i_clk_equ),
    .rst   (i_rst),
    .en    (addr_en),
    .clr   (i_abort),
    .count (addr),
    .tc    (addr_tc)
  );

  equ_mod_cnt #(.MOD(N_SYM), .W(SYM_W)) u_sym_cnt (
    .clk   (i_clk_equ),
    .rst   (i_rst),
    .en    (sym_en),
    .clr   (i_abort),
    .count (sym),
    .tc    (sym_tc)
  );

  always_ff @(posedge i_clk_equ or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      prime_cnt <= '0;
    end else begin
      state     <= state_next;
      prime_cnt <= prime_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    prime_next = prime_cnt;
    unique case (state)
      IDLE: begin
        // Abort outranks start, so a coincident start is dropped.
        if (!i_abort && i_done_equ_one_symbol) begin
          state_next = PRIME;
          prime_next = PRIME_LOAD;
        end
      end
      PRIME: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (prime_cnt == '0) begin
          state_next = SWEEP;
        end else begin
          prime_next = prime_cnt - 1'b1;
        end
      end
      SWEEP: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (!i_stall && addr_tc) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (i_abort) begin
          state_next = IDLE;
        end else if (i_done_equ_one_symbol) begin
          // Back-to-back symbol: skip IDLE and prime straight away.
          state_next = PRIME;
          prime_next = PRIME_LOAD;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign o_rd_add_out  = in_sweep ? addr : '0;
  assign o_rd_valid    = in_sweep && !i_stall;
  assign o_rst_ser_par = !(in_sweep && (addr == '0) && !i_stall);
  assign o_sym_idx     = sym;
  assign o_done_equ    = in_done && !i_abort;
  assign o_done_slot   = in_done && sym_tc && !i_abort;
  assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_equ_sweep_ctrl.sv
// Directed bench for equ_sweep_ctrl: a default-parameter instance and an
// N_SC=16 / PRIME_CYC=3 instance. Outputs are packed as
// {addr[3:0], rd_valid, rst_ser_par, done_equ, done_slot, busy, sym_idx[2:0]}.
module tb_equ_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start, stall, abort;
  logic start16;

  logic [3:0] addr, addr16;
  logic       valid, rsp, done, slot, busy;
  logic       valid16, rsp16, done16, slot16, busy16;
  logic [2:0] sym, sym16;

  int checks = 0;
  int errors = 0;

  equ_sweep_ctrl dut (
    .i_clk_equ             (clk),
    .i_rst                 (rst),
    .i_done_equ_one_symbol (start),
    .i_stall               (stall),
    .i_abort               (abort),
    .o_rd_add_out          (addr),
    .o_rd_valid            (valid),
    .o_rst_ser_par         (rsp),
    .o_sym_idx             (sym),
    .o_done_equ            (done),
    .o_done_slot           (slot),
    .o_busy                (busy)
  );

  equ_sweep_ctrl #(.N_SC(16), .ADDR_W(4), .N_SYM(7), .SYM_W(3), .PRIME_CYC(3)) dut16 (
    .i_clk_equ             (clk),
    .i_rst                 (rst),
    .i_done_equ_one_symbol (start16),
    .i_stall               (1'b0),
    .i_abort               (1'b0),
    .o_rd_add_out          (addr16),
    .o_rd_valid            (valid16),
    .o_rst_ser_par         (rsp16),
    .o_sym_idx             (sym16),
    .o_done_equ            (done16),
    .o_done_slot           (slot16),
    .o_busy                (busy16)
  );

  logic [11:0] obs, obs16;
  assign obs   = {addr, valid, rsp, done, slot, busy, sym};
  assign obs16 = {addr16, valid16, rsp16, done16, slot16, busy16, sym16};

  function automatic logic [11:0] pk(input logic [3:0] a, input logic v, input logic r,
                                     input logic d, input logic s, input logic b,
                                     input logic [2:0] i);
    return {a, v, r, d, s, b, i};
  endfunction

  localparam logic [11:0] IDLE0 = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; stall = 0; abort = 0; start16 = 0;
    rst = 1;
    cyc();
    rst = 0;
  endtask

  // One full symbol with no checking; leaves the DUT in IDLE.
  task automatic run_sym();
    start = 1;
    cyc();
    start = 0;
    repeat (14) cyc();
  endtask

  task automatic test_reset();
    start = 0; stall = 0; abort = 0; start16 = 0;
    rst = 1;
    #1;
    if (obs !== IDLE0) begin errors++; $display("FAIL reset got %h want %h", obs, IDLE0); end
    checks++;
    if (obs16 !== IDLE0) begin errors++; $display("FAIL reset16 got %h want %h", obs16, IDLE0); end
    checks++;
    cyc();
    rst = 0;
  endtask

  task automatic test_single();
    logic [11:0] exp;
    do_reset();
    start = 1; #1;
    if (obs !== IDLE0) begin errors++; $display("FAIL single_t0 got %h want %h", obs, IDLE0); end
    checks++;
    cyc(); start = 0; #1;
    exp = pk(0, 0, 1, 0, 0, 1, 0);
    if (obs !== exp) begin errors++; $display("FAIL single_prime got %h want %h", obs, exp); end
    checks++;
    for (int k = 0; k < 12; k++) begin
      cyc(); #1;
      exp = pk(4'(k), 1, (k != 0), 0, 0, 1, 0);
      if (obs !== exp) begin errors++; $display("FAIL single_addr%0d got %h want %h", k, obs, exp); end
      checks++;
    end
    cyc(); #1;
    exp = pk(0, 0, 1, 1, 0, 1, 0);
    if (obs !== exp) begin errors++; $display("FAIL single_done got %h want %h", obs, exp); end
    checks++;
    cyc(); #1;
    exp = pk(0, 0, 1, 0, 0, 0, 1);
    if (obs !== exp) begin errors++; $display("FAIL single_after got %h want %h", obs, exp); end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    do_reset();
    start = 1;
    for (int s = 0; s < 7; s++) begin
      cyc(); start = 0; #1;
      exp = pk(0, 0, 1, 0, 0, 1, 3'(s));
      if (obs !== exp) begin errors++; $display("FAIL b2b_prime%0d got %h want %h", s, obs, exp); end
      checks++;
      for (int k = 0; k < 12; k++) begin
        cyc(); #1;
        exp = pk(4'(k), 1, (k != 0), 0, 0, 1, 3'(s));
        if (obs !== exp) begin errors++; $display("FAIL b2b_s%0d_a%0d got %h want %h", s, k, obs, exp); end
        checks++;
      end
      cyc();
      start = (s < 6);
      #1;
      exp = pk(0, 0, 1, 1, (s == 6), 1, 3'(s));
      if (obs !== exp) begin errors++; $display("FAIL b2b_done%0d got %h want %h", s, obs, exp); end
      checks++;
    end
    cyc(); start = 0; #1;
    if (obs !== IDLE0) begin errors++; $display("FAIL b2b_wrap got %h want %h", obs, IDLE0); end
    checks++;
  endtask

  task automatic test_stall();
    logic [11:0] exp;
    do_reset();
    start = 1;
    cyc(); start = 0;          // t+1 PRIME
    for (int c = 2; c <= 17; c++) begin
      cyc();
      stall = (c >= 7 && c <= 9);
      #1;
      if (c <= 6)       exp = pk(4'(c - 2), 1, (c != 2), 0, 0, 1, 0);
      else if (c <= 9)  exp = pk(5, 0, 1, 0, 0, 1, 0);
      else if (c == 10) exp = pk(5, 1, 1, 0, 0, 1, 0);
      else if (c <= 16) exp = pk(4'(c - 5), 1, 1, 0, 0, 1, 0);
      else              exp = pk(0, 0, 1, 1, 0, 1, 0);
      if (obs !== exp) begin errors++; $display("FAIL stall_t%0d got %h want %h", c, obs, exp); end
      checks++;
    end
    stall = 0;
  endtask

  task automatic test_abort();
    logic [11:0] exp;
    do_reset();
    run_sym();                 // symbol index now 1
    start = 1;
    cyc(); start = 0;          // PRIME
    repeat (9) cyc();          // address 8
    abort = 1; #1;
    exp = pk(8, 1, 1, 0, 0, 1, 1);
    if (obs !== exp) begin errors++; $display("FAIL abort_cycle got %h want %h", obs, exp); end
    checks++;
    cyc(); abort = 0; #1;
    if (obs !== IDLE0) begin errors++; $display("FAIL abort_idle got %h want %h", obs, IDLE0); end
    checks++;
    repeat (3) begin
      cyc(); #1;
      if (obs !== IDLE0) begin errors++; $display("FAIL abort_quiet got %h want %h", obs, IDLE0); end
      checks++;
    end
    start = 1;
    cyc(); start = 0;
    cyc(); #1;
    exp = pk(0, 1, 0, 0, 0, 1, 0);
    if (obs !== exp) begin errors++; $display("FAIL abort_restart got %h want %h", obs, exp); end
    checks++;
    repeat (12) cyc();         // DONE cycle
    abort = 1; #1;
    exp = pk(0, 0, 1, 0, 0, 1, 0);
    if (obs !== exp) begin errors++; $display("FAIL abort_in_done got %h want %h", obs, exp); end
    checks++;
    cyc(); abort = 0; #1;
    if (obs !== IDLE0) begin errors++; $display("FAIL abort_done_idle got %h want %h", obs, IDLE0); end
    checks++;
  endtask

  task automatic test_ignore_and_rst();
    logic [11:0] exp;
    do_reset();
    start = 1;
    cyc(); start = 0;          // t+1 PRIME
    repeat (4) cyc();          // t+5 address 3
    start = 1; #1;
    exp = pk(3, 1, 1, 0, 0, 1, 0);
    if (obs !== exp) begin errors++; $display("FAIL ign_strobe got %h want %h", obs, exp); end
    checks++;
    cyc(); start = 0; #1;
    exp = pk(4, 1, 1, 0, 0, 1, 0);
    if (obs !== exp) begin errors++; $display("FAIL ign_next got %h want %h", obs, exp); end
    checks++;
    repeat (8) cyc();          // t+14
    #1;
    exp = pk(0, 0, 1, 1, 0, 1, 0);
    if (obs !== exp) begin errors++; $display("FAIL ign_done got %h want %h", obs, exp); end
    checks++;
    exp = pk(0, 0, 1, 0, 0, 0, 1);
    repeat (2) begin
      cyc(); #1;
      if (obs !== exp) begin errors++; $display("FAIL ign_single got %h want %h", obs, exp); end
      checks++;
    end
    start = 1;
    cyc(); start = 0;          // PRIME
    repeat (3) cyc();          // address 2
    #2 rst = 1;                // mid-cycle, away from any edge
    #1;
    if (obs !== IDLE0) begin errors++; $display("FAIL rst_async got %h want %h", obs, IDLE0); end
    checks++;
    cyc(); rst = 0;
    repeat (2) begin
      cyc(); #1;
      if (obs !== IDLE0) begin errors++; $display("FAIL rst_after got %h want %h", obs, IDLE0); end
      checks++;
    end
  endtask

  task automatic test_n16();
    logic [11:0] exp;
    do_reset();
    start16 = 1;
    for (int c = 1; c <= 21; c++) begin
      cyc();
      start16 = 0;
      #1;
      if (c <= 3)       exp = pk(0, 0, 1, 0, 0, 1, 0);
      else if (c <= 19) exp = pk(4'(c - 4), 1, (c != 4), 0, 0, 1, 0);
      else if (c == 20) exp = pk(0, 0, 1, 1, 0, 1, 0);
      else              exp = pk(0, 0, 1, 0, 0, 0, 1);
      if (obs16 !== exp) begin errors++; $display("FAIL n16_t%0d got %h want %h", c, obs16, exp); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_abort();
    test_ignore_and_rst();
    test_n16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/equ_sweep_ctrl.md
Name: equ_sweep_ctrl

Overview:
- Parametrised successor of the per-symbol equalizer controller in the NB-IoT uplink receiver chain.
- On each "symbol ready" strobe, it waits a configurable number of priming cycles.
- It then sweeps read addresses 0..N_SC-1 into the equalizer buffer and resets the serial-to-parallel stage at the sweep start.
- It also counts symbols per slot, supports back-pressure (stall) and abort, and flags per-symbol and per-slot completion.

Parameters:
- N_SC, 12, subcarriers swept per symbol (2..2^ADDR_W).
- ADDR_W, 4, read-address width.
- N_SYM, 7, symbols per slot; sets the symbol-counter wrap.
- SYM_W, 3, symbol-index width, at least clog2(N_SYM).
- PRIME_CYC, 1, idle cycles between start and address 0 (1..15).

Ports:
- i_clk_equ  in  1  block clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_done_equ_one_symbol  in  1  start strobe: one symbol is ready to equalize.
- i_stall  in  1  downstream back-pressure; holds the sweep.
- i_abort  in  1  synchronous abort of the current sweep.
- o_rd_add_out  out  ADDR_W  buffer read address.
- o_rd_valid  out  1  o_rd_add_out is a live read this cycle.
- o_rst_ser_par  out  1  active-low serial-to-parallel reset.
- o_sym_idx  out  SYM_W  index of the symbol being (or last) processed.
- o_done_equ  out  1  one-cycle pulse: symbol sweep complete.
- o_done_slot  out  1  one-cycle pulse: last symbol of the slot complete.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst high, asynchronous):
  - state = IDLE; address counter = 0; symbol counter = 0.
  - o_rd_add_out = 0, o_rd_valid = 0, o_rst_ser_par = 1, o_done_equ = 0, o_done_slot = 0, o_busy = 0, o_sym_idx = 0.
  - Reset mid-sweep discards all progress; no done pulse is produced.
- States are IDLE, PRIME, SWEEP and DONE. The enum holds only these; the default branch goes to IDLE.
- IDLE:
  - Goes to PRIME when i_done_equ_one_symbol = 1; the prime counter loads PRIME_CYC-1.
  - Outputs stay at their reset values.
- PRIME:
  - Decrements the prime counter; goes to SWEEP when it reaches 0.
  - o_rd_valid = 0.
- SWEEP:
  - o_rd_add_out = address counter; o_rd_valid = !i_stall.
  - o_rst_ser_par = 0 only while the counter = 0 and i_stall = 0.
  - With i_stall = 1, the counter holds.
  - Otherwise the counter increments. At N_SC-1 (not stalled), the next state is DONE and the counter clears.
- DONE (exactly one cycle):
  - o_done_equ = 1.
  - o_done_slot = 1 if the symbol counter = N_SYM-1.
  - The symbol counter then increments, wrapping N_SYM-1 to 0.
  - If i_done_equ_one_symbol = 1 in this cycle, go to PRIME (back-to-back symbols); otherwise go to IDLE.
- Start strobes in PRIME or SWEEP are ignored, and no queueing is done. The upstream block must not issue them.
- o_sym_idx = symbol counter, registered, and stable for the whole symbol.
- i_abort:
  - In PRIME, SWEEP or DONE, the next state is IDLE and the address counter clears.
  - The symbol counter resets to 0.
  - No done pulse is given. In a DONE cycle, abort suppresses o_done_equ and o_done_slot.
  - Abort takes priority over stall and start. In IDLE it only clears the symbol counter.
- Latency with no stall, start sampled at cycle t:
  - Address 0 at t+1+PRIME_CYC.
  - Address N_SC-1 at t+PRIME_CYC+N_SC.
  - o_done_equ at t+1+PRIME_CYC+N_SC.
  - Each stall cycle adds one cycle.
- All outputs are decoded combinationally from the state and counters, with no input-to-output path except:
  - o_rd_valid and o_rst_ser_par gated by i_stall.
  - The done pulses gated by i_abort.

Decomposition:
- Package equ_pkg holds the state enum type (IDLE, PRIME, SWEEP, DONE) and shared defaults N_SC_DEF = 12 and N_SYM_DEF = 7.
- One sub-module, equ_mod_cnt: a parametrised modulo counter with enable, clear and terminal-count flag. It is instantiated for the address count and for the symbol count.

Test Plan:
- Default parameters, single start pulse, no stall -> addresses 0..11 at t+2..t+13; o_rst_ser_par low only at t+2; o_done_equ high at t+14; o_sym_idx = 0.
- Seven starts, each issued in the preceding DONE cycle -> continuous sweeps with a 1-cycle PRIME gap; o_done_slot high only on the 7th o_done_equ; o_sym_idx then wraps to 0.
- i_stall high for 3 cycles at address 5 -> address 5 held with o_rd_valid = 0 for those cycles; o_done_equ delayed by 3 (t+17).
- i_abort at address 8 -> IDLE next cycle; o_done_equ never pulses; o_sym_idx = 0; a fresh start restarts at address 0.
- i_rst asserted asynchronously mid-SWEEP -> all outputs at reset values immediately; a start strobe during SWEEP is ignored (single done pulse only).
- N_SC = 16, ADDR_W = 4, PRIME_CYC = 3 -> address 0 at t+4, address 15 at t+19, done at t+20.
